// File: rtl/hba_pkg.sv
// Shared definitions for HBA bus slaves: bus FSM states and GPIO register function codes.
package hba_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StAck  = 2'd1,
        StWait = 2'd2
    } hba_state_e;

    // Function field of the register index {func[2:0], byte[1:0]}.
    localparam logic [2:0] FuncDataOut   = 3'd0;
    localparam logic [2:0] FuncDir       = 3'd1;
    localparam logic [2:0] FuncDataIn    = 3'd2;
    localparam logic [2:0] FuncIntEn     = 3'd3;
    localparam logic [2:0] FuncEdgeSel   = 3'd4;
    localparam logic [2:0] FuncIntStatus = 3'd5;

endpackage

// File: rtl/hba_slave_if.sv
// Generic HBA slave front end: peripheral decode plus IDLE/ACK/WAIT handshake.
// start_o pulses combinationally on the IDLE->ACK transition so the owner can
// commit a write and capture read data on exactly that edge.
module hba_slave_if
    import hba_pkg::*;
#(
    parameter int unsigned PeriphAddrWidth = 4,
    parameter int unsigned RegAddrWidth    = 8,
    parameter int unsigned PeriphAddr      = 0
) (
    input  logic                                    clk_i,
    input  logic                                    rst_ni,
    input  logic                                    select_i,
    input  logic [PeriphAddrWidth+RegAddrWidth-1:0] abus_i,
    output logic                                    start_o,
    output logic                                    ack_o,
    output logic [RegAddrWidth-1:0]                 reg_idx_o
);

    hba_state_e state_q, state_d;
    logic       ack_q;
    logic       hit;

    assign hit = select_i &&
        (abus_i[PeriphAddrWidth+RegAddrWidth-1:RegAddrWidth] == PeriphAddrWidth'(PeriphAddr));
    assign reg_idx_o = abus_i[RegAddrWidth-1:0];
    assign ack_o     = ack_q;

    // Next-state logic; a held select parks in WAIT so it never re-triggers.
    always_comb begin
        state_d = state_q;
        start_o = 1'b0;
        case (state_q)
            StIdle: begin
                if (hit) begin
                    state_d = StAck;
                    start_o = 1'b1;
                end
            end
            StAck:  state_d = StWait;
            StWait: begin
                if (!select_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State register and a dedicated ack flop so the acknowledge is glitch-free.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ack_q   <= (state_d == StAck);
        end
    end

endmodule

// File: rtl/hba_gpio_n.sv
// HBA GPIO slave: up to 32 bidirectional pins with per-pin direction, synchronised
// input sampling, edge-triggered interrupt status and a level interrupt output.
module hba_gpio_n
    import hba_pkg::*;
#(
    parameter int unsigned DBUS_WIDTH        = 8,
    parameter int unsigned PERIPH_ADDR_WIDTH = 4,
    parameter int unsigned REG_ADDR_WIDTH    = 8,
    parameter int unsigned PERIPH_ADDR       = 0,
    parameter int unsigned NUM_PINS          = 8
) (
    input  logic                                      hba_clk,
    input  logic                                      hba_reset,
    input  logic                                      hba_rnw,
    input  logic                                      hba_select,
    input  logic [PERIPH_ADDR_WIDTH+REG_ADDR_WIDTH-1:0] hba_abus,
    input  logic [DBUS_WIDTH-1:0]                     hba_dbus,
    output logic [DBUS_WIDTH-1:0]                     gpio_dbus,
    output logic                                      gpio_xferack,
    output logic                                      gpio_interrupt,
    inout  wire  [NUM_PINS-1:0]                       gpio_port
);

    logic                      start;
    logic                      ack;
    logic [REG_ADDR_WIDTH-1:0] reg_idx;
    logic [2:0]                func;
    logic [1:0]                byte_sel;
    logic                      in_range;
    logic                      wr_en;

    logic [NUM_PINS-1:0] data_out_q, data_out_d;
    logic [NUM_PINS-1:0] dir_q, dir_d;
    logic [NUM_PINS-1:0] int_en_q, int_en_d;
    logic [NUM_PINS-1:0] edge_sel_q, edge_sel_d;
    logic [NUM_PINS-1:0] int_status_q, int_status_d;
    logic [NUM_PINS-1:0] w1c;
    logic [NUM_PINS-1:0] edge_hit;
    logic [NUM_PINS-1:0] sync1_q, sync2_q, sync3_q;
    logic [NUM_PINS-1:0] src;
    logic [DBUS_WIDTH-1:0] rd_val, rd_q;
    logic                  irq_q;

    hba_slave_if #(
        .PeriphAddrWidth(PERIPH_ADDR_WIDTH),
        .RegAddrWidth   (REG_ADDR_WIDTH),
        .PeriphAddr     (PERIPH_ADDR)
    ) u_slave_if (
        .clk_i    (hba_clk),
        .rst_ni   (hba_reset),
        .select_i (hba_select),
        .abus_i   (hba_abus),
        .start_o  (start),
        .ack_o    (ack),
        .reg_idx_o(reg_idx)
    );

    assign func     = reg_idx[4:2];
    assign byte_sel = reg_idx[1:0];
    assign in_range = (reg_idx < REG_ADDR_WIDTH'(32));
    assign wr_en    = start && !hba_rnw && in_range;

    assign gpio_xferack   = ack;
    assign gpio_dbus      = ack ? rd_q : '0;
    assign gpio_interrupt = irq_q;

    for (genvar gi = 0; gi < NUM_PINS; gi++) begin : g_pin
        assign gpio_port[gi] = dir_q[gi] ? data_out_q[gi] : 1'bz;
    end

    // Edge compare uses the synchronised value against its one-cycle-delayed copy.
    assign edge_hit = (sync2_q & ~sync3_q & ~edge_sel_q) | (~sync2_q & sync3_q & edge_sel_q);

    // Read mux: pick the register by function, then the addressed byte lane.
    always_comb begin
        src = '0;
        case (func)
            FuncDataOut:   src = data_out_q;
            FuncDir:       src = dir_q;
            FuncDataIn:    src = sync2_q;
            FuncIntEn:     src = int_en_q;
            FuncEdgeSel:   src = edge_sel_q;
            FuncIntStatus: src = int_status_q;
            default:       src = '0;
        endcase
        rd_val = '0;
        if (in_range) begin
            for (int p = 0; p < NUM_PINS; p++) begin
                if (byte_sel == 2'(p / 8)) begin
                    rd_val[p % 8] = src[p];
                end
            end
        end
    end

    // Register writes for the addressed byte lane; status set beats clear.
    always_comb begin
        data_out_d = data_out_q;
        dir_d      = dir_q;
        int_en_d   = int_en_q;
        edge_sel_d = edge_sel_q;
        w1c        = '0;
        if (wr_en) begin
            for (int p = 0; p < NUM_PINS; p++) begin
                if (byte_sel == 2'(p / 8)) begin
                    case (func)
                        FuncDataOut:   data_out_d[p] = hba_dbus[p % 8];
                        FuncDir:       dir_d[p]      = hba_dbus[p % 8];
                        FuncIntEn:     int_en_d[p]   = hba_dbus[p % 8];
                        FuncEdgeSel:   edge_sel_d[p] = hba_dbus[p % 8];
                        FuncIntStatus: w1c[p]        = hba_dbus[p % 8];
                        default:       ;
                    endcase
                end
            end
        end
        int_status_d = (int_status_q & ~w1c) | edge_hit;
    end

    // Control and status registers.
    always_ff @(posedge hba_clk or negedge hba_reset) begin
        if (!hba_reset) begin
            data_out_q   <= '0;
            dir_q        <= '0;
            int_en_q     <= '0;
            edge_sel_q   <= '0;
            int_status_q <= '0;
        end else begin
            data_out_q   <= data_out_d;
            dir_q        <= dir_d;
            int_en_q     <= int_en_d;
            edge_sel_q   <= edge_sel_d;
            int_status_q <= int_status_d;
        end
    end

    // Two-flop synchroniser on every pin plus one delay stage for edge detection.
    always_ff @(posedge hba_clk or negedge hba_reset) begin
        if (!hba_reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
            sync3_q <= '0;
        end else begin
            sync1_q <= gpio_port;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
        end
    end

    // Read data captured at transfer start; registered interrupt request.
    always_ff @(posedge hba_clk or negedge hba_reset) begin
        if (!hba_reset) begin
            rd_q  <= '0;
            irq_q <= 1'b0;
        end else begin
            if (start) begin
                rd_q <= hba_rnw ? rd_val : '0;
            end
            irq_q <= |(int_status_q & int_en_q);
        end
    end

endmodule

// File: tb/tb_hba_gpio_n.sv
// Scoreboard bench for hba_gpio_n (PERIPH_ADDR=2, NUM_PINS=12) with a mask-level model.
module tb_hba_gpio_n;

    localparam int unsigned PA    = 2;
    localparam int unsigned NP    = 12;
    localparam int unsigned PMASK = 32'h0000_0FFF;

    logic          hba_clk    = 1'b0;
    logic          hba_reset  = 1'b0;
    logic          hba_rnw    = 1'b0;
    logic          hba_select = 1'b0;
    logic [11:0]   hba_abus   = '0;
    logic [7:0]    hba_dbus   = '0;
    wire  [7:0]    gpio_dbus;
    wire           gpio_xferack;
    wire           gpio_interrupt;
    wire  [NP-1:0] gpio_port;

    logic [NP-1:0] tb_en  = '1;
    logic [NP-1:0] tb_val = 12'h020;

    for (genvar gi = 0; gi < NP; gi++) begin : g_drv
        assign gpio_port[gi] = tb_en[gi] ? tb_val[gi] : 1'bz;
    end

    always #5 hba_clk = ~hba_clk;

    hba_gpio_n #(
        .DBUS_WIDTH       (8),
        .PERIPH_ADDR_WIDTH(4),
        .REG_ADDR_WIDTH   (8),
        .PERIPH_ADDR      (PA),
        .NUM_PINS         (NP)
    ) dut (
        .hba_clk       (hba_clk),
        .hba_reset     (hba_reset),
        .hba_rnw       (hba_rnw),
        .hba_select    (hba_select),
        .hba_abus      (hba_abus),
        .hba_dbus      (hba_dbus),
        .gpio_dbus     (gpio_dbus),
        .gpio_xferack  (gpio_xferack),
        .gpio_interrupt(gpio_interrupt),
        .gpio_port     (gpio_port)
    );

    int checks    = 0;
    int passes    = 0;
    int ack_count = 0;
    logic [7:0] sb[$];

    // Model state as plain pin masks.
    int unsigned m_dout, m_dir, m_ien, m_esel, m_stat, m_tbv, m_eff;

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endfunction

    function automatic void pins_update();
        int unsigned nw, rise, fall;
        nw     = ((m_dir & m_dout) | (~m_dir & m_tbv)) & PMASK;
        rise   = nw & ~m_eff;
        fall   = m_eff & ~nw;
        m_stat = m_stat | (rise & ~m_esel) | (fall & m_esel);
        m_eff  = nw;
    endfunction

    function automatic void model_reset();
        m_dout = 0; m_dir = 0; m_ien = 0; m_esel = 0; m_stat = 0; m_eff = 0;
        tb_en  = '1;
    endfunction

    function automatic void model_write(input int unsigned idx, input logic [7:0] wd);
        int unsigned f, m, d;
        if (idx < 32) begin
            f = idx / 4;
            m = (32'hFF << (8 * (idx % 4))) & PMASK;
            d = (32'(wd) << (8 * (idx % 4))) & m;
            case (f)
                0: m_dout = (m_dout & ~m) | d;
                1: m_dir  = (m_dir & ~m) | d;
                3: m_ien  = (m_ien & ~m) | d;
                4: m_esel = (m_esel & ~m) | d;
                5: m_stat = m_stat & ~d;
                default: ;
            endcase
        end
        pins_update();
        tb_en = ~m_dir[NP-1:0];
    endfunction

    function automatic logic [7:0] model_read(input int unsigned idx);
        int unsigned v;
        v = 0;
        if (idx < 32) begin
            case (idx / 4)
                0: v = m_dout;
                1: v = m_dir;
                2: v = m_eff;
                3: v = m_ien;
                4: v = m_esel;
                5: v = m_stat;
                default: v = 0;
            endcase
        end
        return 8'((v >> (8 * (idx % 4))) & 32'hFF);
    endfunction

    task automatic drive_pins(input logic [NP-1:0] val, input bit upd);
        tb_val = val;
        m_tbv  = 32'(val);
        if (upd) begin
            pins_update();
            repeat (4) @(negedge hba_clk);
        end
    endtask

    task automatic xfer(input bit rnw, input int unsigned periph, input int unsigned idx,
                        input logic [7:0] wd, input logic [7:0] exp, input int unsigned hold);
        bit hit;
        logic [3:0] pf;
        logic [7:0] ix;
        hit = (periph == PA);
        pf  = 4'(periph);
        ix  = 8'(idx);
        @(negedge hba_clk);
        hba_select = 1'b1;
        hba_rnw    = rnw;
        hba_abus   = {pf, ix};
        hba_dbus   = wd;
        if (hit) sb.push_back(rnw ? exp : 8'h00);
        @(posedge hba_clk);
        #1;
        if (hit && !rnw) model_write(idx, wd);
        repeat (hold) @(negedge hba_clk);
        hba_select = 1'b0;
        repeat (4) @(negedge hba_clk);
        check("ack_consumed", sb.size(), 0);
        sb.delete();
    endtask

    task automatic wr(input int unsigned idx, input logic [7:0] wd);
        xfer(1'b0, PA, idx, wd, 8'h00, 2);
    endtask

    task automatic rdc(input int unsigned idx, input logic [7:0] exp);
        xfer(1'b1, PA, idx, 8'h00, exp, 2);
    endtask

    // Monitor: every ack consumes one scoreboard entry; idle cycles must show zero data.
    always @(negedge hba_clk) begin : mon
        logic [7:0] e;
        if (hba_reset) begin
            if (gpio_xferack === 1'b1) begin
                ack_count++;
                if (sb.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_ack: ack with nothing pending, dbus=%0h", gpio_dbus);
                end else begin
                    e = sb.pop_front();
                    check("read_data", 32'(gpio_dbus), 32'(e));
                end
            end else begin
                check("idle_dbus_zero", 32'(gpio_dbus), 0);
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin : stim
        int a0;
        int unsigned op, idx, per;
        logic [7:0] d;
        model_reset();
        m_tbv = 32'h020;
        repeat (3) @(negedge hba_clk);
        check("rst_xferack", 32'(gpio_xferack), 0);
        check("rst_dbus", 32'(gpio_dbus), 0);
        check("rst_irq", 32'(gpio_interrupt), 0);
        hba_reset = 1'b1;
        pins_update();
        repeat (5) @(negedge hba_clk);

        // Pin high at release: single rising edge
        rdc(8'h14, 8'h20);
        wr(8'h14, 8'hFF);
        rdc(8'h14, 8'h00);

        // Output path
        wr(8'h00, 8'h5A);
        wr(8'h04, 8'hFF);
        rdc(8'h00, 8'h5A);
        check("pins_out", 32'(gpio_port[7:0]), 32'h5A);

        // Input synchroniser latency
        wr(8'h14, 8'hFF);
        drive_pins(12'h000, 1'b1);
        wr(8'h04, 8'h00);
        rdc(8'h08, 8'h00);
        drive_pins(12'h008, 1'b0);
        rdc(8'h08, 8'h00);
        pins_update();
        rdc(8'h08, 8'h08);

        // Rising-edge interrupt and W1C
        wr(8'h14, 8'hFF);
        wr(8'h0C, 8'h01);
        wr(8'h10, 8'h00);
        drive_pins(12'h009, 1'b1);
        rdc(8'h14, 8'h01);
        check("irq_set", 32'(gpio_interrupt), 1);
        wr(8'h14, 8'h01);
        rdc(8'h14, 8'h00);
        check("irq_clr", 32'(gpio_interrupt), 0);

        // W1C colliding with a new rising edge
        drive_pins(12'h008, 1'b1);
        drive_pins(12'h009, 1'b1);
        drive_pins(12'h008, 1'b1);
        drive_pins(12'h009, 1'b0);
        @(negedge hba_clk);
        wr(8'h14, 8'h01);
        pins_update();
        rdc(8'h14, 8'h01);
        check("irq_set_wins", 32'(gpio_interrupt), 1);

        // Bits above NUM_PINS, unused funcs, out-of-range index
        wr(8'h01, 8'hFF);
        rdc(8'h01, 8'h0F);
        rdc(8'h02, 8'h00);
        wr(8'h02, 8'hFF);
        rdc(8'h02, 8'h00);
        wr(8'h18, 8'hFF);
        rdc(8'h18, 8'h00);
        wr(8'h20, 8'hFF);
        rdc(8'h20, 8'h00);

        // Peripheral decode and held select
        a0 = ack_count;
        xfer(1'b1, 1, 8'h00, 8'h00, 8'h00, 3);
        check("no_ack_other_periph", 32'(ack_count - a0), 0);
        a0 = ack_count;
        xfer(1'b1, PA, 8'h01, 8'h00, 8'h0F, 10);
        check("one_ack_held", 32'(ack_count - a0), 1);

        // Reset mid-transfer, select still high afterwards
        @(negedge hba_clk);
        hba_select = 1'b1;
        hba_rnw    = 1'b1;
        hba_abus   = {4'(PA), 8'h01};
        #2;
        hba_reset = 1'b0;
        model_reset();
        @(negedge hba_clk);
        check("midrst_xferack", 32'(gpio_xferack), 0);
        check("midrst_dbus", 32'(gpio_dbus), 0);
        a0 = ack_count;
        sb.push_back(8'h00);
        hba_reset = 1'b1;
        pins_update();
        repeat (3) @(negedge hba_clk);
        hba_select = 1'b0;
        repeat (4) @(negedge hba_clk);
        check("midrst_rehit_ack", 32'(ack_count - a0), 1);
        check("midrst_sb_empty", sb.size(), 0);
        sb.delete();

        // Randomised traffic against the model
        for (int it = 0; it < 250; it++) begin
            op  = $urandom_range(0, 9);
            idx = $urandom_range(0, 31);
            if ($urandom_range(0, 7) == 0) idx = $urandom_range(32, 255);
            per = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 15) : PA;
            d   = 8'($urandom);
            if (op <= 3) begin
                xfer(1'b0, per, idx, d, 8'h00, $urandom_range(1, 4));
            end else if (op <= 6) begin
                xfer(1'b1, per, idx, 8'h00, model_read(idx), $urandom_range(1, 4));
            end else begin
                drive_pins(12'($urandom), 1'b1);
            end
            check("irq_level", 32'(gpio_interrupt), 32'(|(m_stat & m_ien)));
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/hba_gpio_n.md
HBA_GPIO_N -- requirements
Module: hba_gpio_n

Interface
REQ-001 SHALL have parameter DBUS_WIDTH, default 8, data bus width (only 8 is supported).
REQ-002 SHALL have parameter PERIPH_ADDR_WIDTH, default 4, peripheral-select field width.
REQ-003 SHALL have parameter REG_ADDR_WIDTH, default 8, register-index field width.
REQ-004 SHALL have parameter PERIPH_ADDR, default 0, peripheral number this slave answers to.
REQ-005 SHALL have parameter NUM_PINS, default 8, GPIO pin count, legal range 1..32.
REQ-006 SHALL have port hba_clk, input, 1, the single clock; all logic on its rising edge.
REQ-007 SHALL have port hba_reset, input, 1, asynchronous active-low reset.
REQ-008 SHALL have port hba_rnw, input, 1, 1=read, 0=write.
REQ-009 SHALL have port hba_select, input, 1, transfer in progress.
REQ-010 SHALL have port hba_abus, input, PERIPH_ADDR_WIDTH+REG_ADDR_WIDTH, {periph, reg}.
REQ-011 SHALL have port hba_dbus, input, DBUS_WIDTH, write data.
REQ-012 SHALL have port gpio_dbus, output, DBUS_WIDTH, read data; zero when not acking.
REQ-013 SHALL have port gpio_xferack, output, 1, transfer acknowledge; zero when inactive.
REQ-014 SHALL have port gpio_interrupt, output, 1, level interrupt request.
REQ-015 SHALL have port gpio_port, inout, NUM_PINS, GPIO pins.

Function
REQ-016 Selection: hit = hba_select AND hba_abus[MSB:REG_ADDR_WIDTH]==PERIPH_ADDR.
REQ-017 Bus FSM states IDLE, ACK, WAIT; IDLE->ACK on hit; ACK->WAIT unconditionally; WAIT->IDLE when hba_select=0.
REQ-018 gpio_xferack SHALL be 1 only in ACK: exactly one cycle, registered, asserted the cycle after hit is first seen.
REQ-019 Read data SHALL be registered on the IDLE->ACK transition and driven on gpio_dbus only while in ACK.
REQ-020 Writes SHALL take effect on the IDLE->ACK edge; a held hba_select SHALL never cause a second write or ack.
REQ-021 Reg index = {func[2:0], byte[1:0]}; byte selects pins [8*byte+7 : 8*byte].
REQ-022 func 0 DATA_OUT (RW), 1 DIR (RW, 1=output), 2 DATA_IN (RO), 3 INT_EN (RW), 4 EDGE_SEL (RW, 0=rising, 1=falling), 5 INT_STATUS (read; write-1-to-clear).
REQ-023 func 6..7, index >= 32, and bits at or above NUM_PINS SHALL read 0; writes to them SHALL be ignored, but still acked.
REQ-024 gpio_port[i] SHALL be driven with DATA_OUT[i] when DIR[i]=1, else high-Z.
REQ-025 Each pin SHALL pass through a 2-flop synchroniser; DATA_IN = synchronised value (2-cycle latency).
REQ-026 Edge detect on synchronised value vs its 1-cycle-delayed copy; a selected edge sets INT_STATUS[i] regardless of INT_EN.
REQ-027 Same-cycle edge and W1C on one bit: set SHALL win.
REQ-028 gpio_interrupt SHALL be registered OR of (INT_STATUS AND INT_EN); it is 1 the cycle after the status bit sets.
REQ-029 Output pins SHALL also be sampled; an output pin toggled by DATA_OUT SHALL generate edges.

Reset
REQ-030 On hba_reset=0, asynchronously: FSM=IDLE; gpio_xferack=0; gpio_dbus=0; gpio_interrupt=0; all registers and synchronisers 0 (all pins inputs, high-Z).
REQ-031 Reset mid-transfer SHALL abort without ack; after release with hba_select still high, the FSM SHALL treat it as a new hit.
REQ-032 Synchroniser and edge flops reset to 0; a pin held high at release SHALL set a rising edge at most once.

Structure
REQ-033 Func codes (DATA_OUT..INT_STATUS) and FSM state encodings SHALL live in shared package hba_pkg.
REQ-034 One sub-module hba_slave_if SHALL hold address decode and the IDLE/ACK/WAIT FSM, reusable by other slaves.

Verification
REQ-035 Write 0x5A to reg 0x00, then 0xFF to reg 0x04; read reg 0x00 -> 0x5A, ack 1 cycle, pins[7:0]=0x5A.
REQ-036 DIR=0x00; drive pin 3 high; read DATA_IN reg 0x08 -> 0x08 no earlier than 2 cycles after drive.
REQ-037 INT_EN=0x01, EDGE_SEL=0; pin0 0->1 -> INT_STATUS=0x01, gpio_interrupt=1; write 0x01 to reg 0x14 -> both 0.
REQ-038 W1C to bit0 in same cycle as new rising edge on pin0 -> INT_STATUS bit0 stays 1.
REQ-039 PERIPH_ADDR=2, access periph 1 -> no ack, gpio_dbus=0; hold select 10 cycles on periph 2 -> exactly one ack.
REQ-040 NUM_PINS=12: write 0xFF to reg 0x01, read back -> 0x0F; read reg 0x02 -> 0x00.
